// File: rtl/gpu_fetch_pkg.sv
// Shared types and constants for the GPU instruction prefetch path.
package gpu_fetch_pkg;
    localparam int INSW = 16;
    localparam int LWW  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    function automatic int q_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/gpu_hw_fifo.sv
// Halfword FIFO accepting 0, 1 or 2 words per cycle and releasing one.
module gpu_hw_fifo
    import gpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clr,
    input  logic [1:0]                        push_n,
    input  logic [INSW-1:0]                   push_d0,
    input  logic [INSW-1:0]                   push_d1,
    input  logic                              pop,
    output logic [INSW-1:0]                   head,
    output logic [q_count_width(DEPTH)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = q_count_width(DEPTH);

    logic [INSW-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // PW'(push_n) wraps correctly because DEPTH is a power of two
            wr_ptr <= wr_ptr + PW'(push_n);
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            if (push_n != 2'd0)
                mem[wr_ptr] <= push_d0;
            if (push_n == 2'd2)
                mem[wr_ptr + 1'b1] <= push_d1;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/gpu_ifetch_queue.sv
// Instruction prefetch: fetches long words, splits them into big-endian
// halfwords and presents them with their PCs to the execute stage.
//
// state | meaning
// IDLE  | no request outstanding; issue one when enabled and 2 words of room
// REQ   | progreq held with stable progaddr until progack
module gpu_ifetch_queue
    import gpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              go,
    input  logic                              flush,
    input  logic [AW-1:0]                     flush_pc,
    output logic                              progreq,
    output logic [AW-3:0]                     progaddr,
    input  logic                              progack,
    input  logic [LWW-1:0]                    progdata,
    output logic                              ins_valid,
    output logic [INSW-1:0]                   ins_word,
    output logic [AW-1:0]                     ins_pc,
    input  logic                              ins_take,
    output logic [q_count_width(DEPTH)-1:0]   q_count
);
    localparam int CW = q_count_width(DEPTH);

    fetch_state_t    state;
    logic [AW-3:0]   fetch_addr;
    logic            skip;
    logic            discard;

    logic            ack_live;
    logic            push_ok;
    logic            pop;
    logic            has_room;
    logic [1:0]      push_n;
    logic [INSW-1:0] push_d0;
    logic [INSW-1:0] fifo_head;

    assign ack_live = (state == REQ) && progack;
    assign push_ok  = ack_live && !discard && !flush;
    assign pop      = ins_valid && ins_take && !flush;
    assign push_n   = push_ok ? (skip ? 2'd1 : 2'd2) : 2'd0;
    assign push_d0  = skip ? progdata[INSW-1:0] : progdata[LWW-1:INSW];
    // Only checked in IDLE, so the in-flight request is already accounted for
    assign has_room = ({1'b0, q_count} + (CW+1)'(2)) <= (CW+1)'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            progreq    <= 1'b0;
            progaddr   <= '0;
            fetch_addr <= '0;
            skip       <= 1'b0;
            discard    <= 1'b0;
            ins_pc     <= '0;
        end else begin
            if (flush) begin
                fetch_addr <= flush_pc[AW-1:2];
                skip       <= flush_pc[1];
                ins_pc     <= flush_pc & ~AW'(1);
            end else begin
                if (push_ok) begin
                    fetch_addr <= fetch_addr + 1'b1;
                    skip       <= 1'b0;
                end
                if (pop)
                    ins_pc <= ins_pc + AW'(2);
            end

            case (state)
                IDLE: begin
                    if (go && !flush && has_room) begin
                        progreq  <= 1'b1;
                        progaddr <= fetch_addr;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (progack) begin
                        progreq <= 1'b0;
                        discard <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    gpu_hw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (flush),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (progdata[INSW-1:0]),
        .pop     (pop),
        .head    (fifo_head),
        .count   (q_count)
    );

    assign ins_valid = (q_count != '0);
    assign ins_word  = ins_valid ? fifo_head : '0;
endmodule

// File: tb/tb_gpu_ifetch_queue.sv
// Bench for gpu_ifetch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_gpu_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 24;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          progreq;
    logic [AW-3:0] progaddr;
    logic          progack;
    logic [31:0]   progdata;
    logic          ins_valid;
    logic [15:0]   ins_word;
    logic [AW-1:0] ins_pc;
    logic          ins_take;
    logic [CW-1:0] q_count;

    gpu_ifetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .progreq   (progreq),
        .progaddr  (progaddr),
        .progack   (progack),
        .progdata  (progdata),
        .ins_valid (ins_valid),
        .ins_word  (ins_word),
        .ins_pc    (ins_pc),
        .ins_take  (ins_take),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued words in order, PC of the head, fetch pointer
    logic [15:0]   m_word[$];
    logic [AW-1:0] m_pc;
    logic [AW-3:0] m_faddr;
    logic [AW-3:0] m_raddr;
    bit            m_skip;
    bit            m_stale;
    bit            m_req;

    task automatic model_reset();
        m_word.delete();
        m_pc    = '0;
        m_faddr = '0;
        m_raddr = '0;
        m_skip  = 1'b0;
        m_stale = 1'b0;
        m_req   = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input bit g, input bit f, input logic [AW-1:0] fp,
                         input bit tk, input bit ak, input logic [31:0] d);
        bit req_pre;
        int sz;
        go = g; flush = f; flush_pc = fp; ins_take = tk; progack = ak; progdata = d;
        sz = m_word.size();
        chk("progreq", 32'(progreq), 32'(m_req));
        if (m_req)
            chk("progaddr", 32'(progaddr), 32'(m_raddr));
        chk("q_count", 32'(q_count), 32'(sz));
        chk("ins_valid", 32'(ins_valid), 32'(sz != 0));
        chk("ins_pc", 32'(ins_pc), 32'(m_pc));
        chk("ins_word", 32'(ins_word), (sz != 0) ? 32'(m_word[0]) : 32'h0);
        @(posedge clk);
        req_pre = m_req;
        if (f) begin
            m_word.delete();
            m_pc    = fp & ~AW'(1);
            m_faddr = fp[AW-1:2];
            m_skip  = fp[1];
            if (req_pre) begin
                if (ak) begin
                    m_req   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (tk && sz > 0) begin
                void'(m_word.pop_front());
                m_pc = m_pc + AW'(2);
            end
            if (req_pre && ak) begin
                m_req = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    if (!m_skip)
                        m_word.push_back(d[31:16]);
                    m_word.push_back(d[15:0]);
                    m_skip  = 1'b0;
                    m_faddr = m_faddr + 1'b1;
                end
            end
        end
        if (!req_pre && g && !f && (sz + 2 <= DEPTH)) begin
            m_req   = 1'b1;
            m_raddr = m_faddr;
        end
        @(negedge clk);
    endtask

    task automatic fetch_one(input logic [31:0] d, input int delay, output logic [AW-3:0] addr);
        int n = 0;
        while (!progreq && n < 20) begin
            cycle(1, 0, '0, 0, 0, '0);
            n++;
        end
        chk("req_timeout", 32'(progreq), 32'h1);
        addr = progaddr;
        repeat (delay) cycle(1, 0, '0, 0, 0, '0);
        cycle(1, 0, '0, 0, 1, d);
    endtask

    logic [AW-3:0] a;
    logic [15:0]   exp_w [4];
    int            n_req;

    initial begin
        reset = 1'b1; go = 0; flush = 0; flush_pc = '0; progack = 0;
        progdata = '0; ins_take = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_progreq", 32'(progreq), 0);
        chk("rst_q_count", 32'(q_count), 0);
        reset = 1'b0;

        // Aligned stream
        cycle(1, 1, 24'h000100, 0, 0, '0);
        fetch_one(32'h98E0_A411, 1, a);
        chk("t1_addr0", 32'(a), 32'h40);
        chk("t1_latency_valid", 32'(ins_valid), 1);
        chk("t1_q2", 32'(q_count), 2);
        fetch_one(32'h1234_5678, 1, a);
        chk("t1_addr1", 32'(a), 32'h41);
        exp_w = '{16'h98E0, 16'hA411, 16'h1234, 16'h5678};
        for (int i = 0; i < 4; i++) begin
            chk("t1_word", 32'(ins_word), 32'(exp_w[i]));
            chk("t1_pc", 32'(ins_pc), 32'h100 + 32'(2 * i));
            cycle(0, 0, '0, 1, 0, '0);
        end

        // Misaligned start
        cycle(1, 1, 24'h000102, 0, 0, '0);
        fetch_one(32'hDEAD_BEEF, 0, a);
        chk("t2_addr", 32'(a), 32'h40);
        chk("t2_word", 32'(ins_word), 32'hBEEF);
        chk("t2_pc", 32'(ins_pc), 32'h102);
        chk("t2_q1", 32'(q_count), 1);

        // Backpressure
        cycle(1, 1, 24'h000200, 0, 0, '0);
        n_req = 0;
        for (int i = 0; i < 12; i++) begin
            if (progreq) n_req++;
            cycle(1, 0, '0, 0, progreq, $urandom());
        end
        chk("t3_nreq", 32'(n_req), 2);
        chk("t3_q4", 32'(q_count), 4);
        cycle(1, 0, '0, 1, 0, '0);
        repeat (3) cycle(1, 0, '0, 0, 0, '0);
        chk("t3_hold", 32'(progreq), 0);
        cycle(1, 0, '0, 1, 0, '0);
        cycle(1, 0, '0, 0, 0, '0);
        chk("t3_resume", 32'(progreq), 1);

        // Flush while a request is pending; its data must be dropped
        cycle(1, 1, 24'h000400, 0, 0, '0);
        repeat (2) cycle(1, 0, '0, 0, 0, '0);
        chk("t4_still_req", 32'(progreq), 1);
        cycle(1, 0, '0, 0, 1, 32'h1111_2222);
        fetch_one(32'hAAAA_5555, 0, a);
        chk("t4_addr", 32'(a), 32'h100);
        chk("t4_word", 32'(ins_word), 32'hAAAA);
        chk("t4_q2", 32'(q_count), 2);

        // Flush + take + ack in one cycle
        cycle(1, 0, '0, 0, 0, '0);
        chk("t5_req", 32'(progreq), 1);
        cycle(1, 1, 24'h000500, 1, 1, 32'h7777_8888);
        chk("t5_q0", 32'(q_count), 0);
        chk("t5_valid", 32'(ins_valid), 0);
        chk("t5_pc", 32'(ins_pc), 32'h500);

        // Asynchronous reset in the middle of a request
        fetch_one(32'h3333_4444, 0, a);
        cycle(1, 0, '0, 0, 0, '0);
        chk("t6_req", 32'(progreq), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_progreq", 32'(progreq), 0);
        chk("t6_progaddr", 32'(progaddr), 0);
        chk("t6_valid", 32'(ins_valid), 0);
        chk("t6_word", 32'(ins_word), 0);
        chk("t6_pc", 32'(ins_pc), 0);
        chk("t6_q", 32'(q_count), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, '0, 0, 1, 32'h5555_AAAA);
        cycle(0, 0, '0, 0, 0, '0);
        chk("t6_ack_ignored", 32'(q_count), 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] fp;
            fp = AW'($urandom());
            cycle(($urandom() % 8) != 0, ($urandom() % 40) == 0, fp,
                  $urandom() % 2, progreq && (($urandom() % 3) == 0), $urandom());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
